// File: rtl/memory_ctl.sv
// MEM stage of a 5-stage RV32 pipeline: EX/MEM register, data-memory request FSM with wait
// states, byte-lane steering, load extraction and the MEM/WB writeback register.
module memory_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] alu_result,
    input  logic [31:0] data_b_exe,
    input  logic [31:0] pc_exe,
    input  logic [31:0] instr_exe,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_exc
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    typedef enum logic {StIdle, StAccess} state_t;

    state_t state_q, state_d;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    endfunction

    // f3[1:0] encodes access size for both loads and stores (00 byte, 01 half, 10 word).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    // EX-side decode, used to launch the request at the capture edge
    logic [6:0] ex_opcode;
    logic [2:0] ex_f3;
    logic       ex_load, ex_store, ex_mis, start_access;
    logic [1:0] ex_a;
    logic [3:0] ex_be;
    logic [31:0] ex_wdata;

    assign ex_opcode    = instr_exe[6:0];
    assign ex_f3        = instr_exe[14:12];
    assign ex_a         = alu_result[1:0];
    assign ex_load      = (ex_opcode == OpLoad) && load_f3_ok(ex_f3);
    assign ex_store     = (ex_opcode == OpStore) && store_f3_ok(ex_f3);
    assign ex_mis       = is_misaligned(ex_f3, ex_a);
    assign start_access = ~mem_stall & ~flush & (ex_load | ex_store) & ~ex_mis;

    always_comb begin
        ex_be    = 4'b1111;
        ex_wdata = data_b_exe;
        case (ex_f3[1:0])
            2'b00: begin
                ex_be    = 4'b0001 << ex_a;
                ex_wdata = {4{data_b_exe[7:0]}};
            end
            2'b01: begin
                ex_be    = 4'b0011 << ex_a;
                ex_wdata = {2{data_b_exe[15:0]}};
            end
            default: begin
                ex_be    = 4'b1111;
                ex_wdata = data_b_exe;
            end
        endcase
    end

    assign mem_stall = (state_q == StAccess) & ~dmem_ack;
    assign dmem_req  = (state_q == StAccess);

    always_comb begin
        state_d = state_q;
        if (start_access) begin
            state_d = StAccess;
        end else if ((state_q == StAccess) && dmem_ack) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are held until the ack edge; a back-to-back op reloads them on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_addr  <= 32'd0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
        end else if (start_access) begin
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_we    <= ex_store;
            dmem_be    <= ex_be;
            dmem_wdata <= ex_wdata;
        end else if ((state_q == StAccess) && dmem_ack) begin
            dmem_we <= 1'b0;
            dmem_be <= 4'd0;
        end
    end

    // EX/MEM stage register
    logic        m_valid;
    logic [31:0] m_instr, m_alu, m_b, m_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_instr <= 32'd0;
            m_alu   <= 32'd0;
            m_b     <= 32'd0;
            m_pc    <= 32'd0;
        end else if (!mem_stall) begin
            m_valid <= ~flush;
            m_instr <= instr_exe;
            m_alu   <= alu_result;
            m_b     <= data_b_exe;
            m_pc    <= pc_exe;
        end
    end

    logic unused_m;
    assign unused_m = ^{m_instr[31:15], m_b};

    // MEM-side decode and retirement
    logic [6:0]  m_opcode;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic        m_load, m_store, m_mis, retire, rd_writer, wb_we_d;
    logic [31:0] lane, load_data, wb_data_d;

    assign m_opcode = m_instr[6:0];
    assign m_f3     = m_instr[14:12];
    assign m_rd     = m_instr[11:7];
    assign m_load   = (m_opcode == OpLoad) && load_f3_ok(m_f3);
    assign m_store  = (m_opcode == OpStore) && store_f3_ok(m_f3);
    assign m_mis    = (m_load | m_store) & is_misaligned(m_f3, m_alu[1:0]);
    assign retire   = m_valid & ~mem_stall;

    assign lane = dmem_rdata >> {m_alu[1:0], 3'b000};

    always_comb begin
        load_data = lane;
        case (m_f3)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    assign rd_writer = (m_opcode == OpLui) || (m_opcode == OpAuipc) || (m_opcode == OpJal) ||
                       (m_opcode == OpJalr) || (m_opcode == OpOpImm) || (m_opcode == OpOp) ||
                       (m_load && !m_mis);
    assign wb_we_d   = retire & rd_writer & (m_rd != 5'd0);

    always_comb begin
        wb_data_d = m_alu;
        if (m_load) begin
            wb_data_d = load_data;
        end else if ((m_opcode == OpJal) || (m_opcode == OpJalr)) begin
            wb_data_d = m_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            misalign_exc <= 1'b0;
        end else begin
            wb_we        <= wb_we_d;
            misalign_exc <= retire & m_mis;
            if (retire) begin
                wb_rd   <= m_rd;
                wb_data <= wb_data_d;
            end
        end
    end

endmodule
